// File: rtl/ffe_weight_sequencer_if.sv
// ---------------------------------------------------------------------------
// ffe_weight_sequencer_if
//   Groups the command handshake, the weight-memory write port and the
//   status outputs of ffe_weight_sequencer into one bundle.
//
//   Handshake: a command transfers on a rising clk_adc edge where req_valid
//   and req_ready are both high. The requester keeps the req_* fields valid
//   while req_valid is high. The fields only have to be valid at that edge,
//   because the sequencer latches them when it accepts the command.
//
//   Signals
//     req_valid/req_ready       command handshake
//     req_clear/req_bcast       command kind (clear > bcast > single)
//     req_d_idx/req_w_idx       tap / lane index
//     req_value                 weight value (two's complement)
//     wme_ffe_inst/data/exec    weight-memory write port
//     busy/done/err/wr_count    status
//     state_dbg                 current sequencer FSM state (debug)
//
//   Modports
//     master : command source / status sink
//     slave  : the sequencer
// ---------------------------------------------------------------------------
interface ffe_weight_sequencer_if #(
  parameter int FFE_LENGTH    = 10,
  parameter int CHANNEL_WIDTH = 16,
  parameter int WEIGHT_PREC   = 10,
  parameter int CNT_W         = 16
);
  localparam int DW = $clog2(FFE_LENGTH);
  localparam int WW = $clog2(CHANNEL_WIDTH);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_clear;
  logic                   req_bcast;
  logic [DW-1:0]          req_d_idx;
  logic [WW-1:0]          req_w_idx;
  logic [WEIGHT_PREC-1:0] req_value;

  logic [DW+WW:0]         wme_ffe_inst;
  logic [WEIGHT_PREC-1:0] wme_ffe_data;
  logic                   wme_ffe_exec;

  logic                   busy;
  logic                   done;
  logic                   err;
  logic [CNT_W-1:0]       wr_count;
  logic [1:0]             state_dbg;

  modport master (
    output req_valid, req_clear, req_bcast, req_d_idx, req_w_idx, req_value,
    input  req_ready, wme_ffe_inst, wme_ffe_data, wme_ffe_exec,
    input  busy, done, err, wr_count, state_dbg
  );

  modport slave (
    input  req_valid, req_clear, req_bcast, req_d_idx, req_w_idx, req_value,
    output req_ready, wme_ffe_inst, wme_ffe_data, wme_ffe_exec,
    output busy, done, err, wr_count, state_dbg
  );
endinterface

// File: rtl/ffe_weight_sequencer.sv
// ---------------------------------------------------------------------------
// ffe_weight_sequencer
//   Drives the FFE weight-memory write port. A command writes one weight
//   (single), one tap across every lane (bcast), or zero into every
//   (tap, lane) entry (clear). Each weight write takes three cycles:
//   SETUP (address/data valid), EXEC (one-cycle strobe) and HOLD
//   (address/data still stable).
//
//   Ports
//     clk_adc : ADC-domain clock, all logic on the rising edge
//     rstb    : asynchronous active-low reset
//     bus     : ffe_weight_sequencer_if.slave (handshake, write port, status)
// ---------------------------------------------------------------------------
module ffe_weight_sequencer #(
  parameter int FFE_LENGTH    = 10,
  parameter int CHANNEL_WIDTH = 16,
  parameter int WEIGHT_PREC   = 10,
  parameter int CNT_W         = 16
) (
  input  logic                          clk_adc,
  input  logic                          rstb,
  ffe_weight_sequencer_if.slave         bus
);
  localparam int DW = $clog2(FFE_LENGTH);
  localparam int WW = $clog2(CHANNEL_WIDTH);

  localparam logic [DW-1:0] D_LAST = DW'(FFE_LENGTH - 1);
  localparam logic [WW-1:0] W_LAST = WW'(CHANNEL_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_EXEC  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_SINGLE = 2'd0,
    M_BCAST  = 2'd1,
    M_CLEAR  = 2'd2
  } mode_t;

  state_t                 state_q, state_d;
  mode_t                  mode_q,  mode_d;
  logic [DW-1:0]          d_q,     d_d;
  logic [WW-1:0]          w_q,     w_d;
  logic [WEIGHT_PREC-1:0] val_q,   val_d;
  logic                   err_q,   err_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;

  logic d_ok, w_ok, w_last, d_last, cmd_last;

  // Widen the request indices before comparing them, so that the check
  // still works when the index field can encode more values than exist.
  assign d_ok   = int'(bus.req_d_idx) < FFE_LENGTH;
  assign w_ok   = int'(bus.req_w_idx) < CHANNEL_WIDTH;
  assign w_last = (w_q == W_LAST);
  assign d_last = (d_q == D_LAST);

  // The current weight is the final weight of the running command.
  always_comb begin
    cmd_last = 1'b1;
    case (mode_q)
      M_SINGLE: cmd_last = 1'b1;
      M_BCAST:  cmd_last = w_last;
      M_CLEAR:  cmd_last = w_last && d_last;
      default:  cmd_last = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    d_d     = d_q;
    w_d     = w_q;
    val_d   = val_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_clear) begin
            mode_d  = M_CLEAR;
            d_d     = '0;
            w_d     = '0;
            val_d   = '0;
            state_d = S_SETUP;
          end else if (bus.req_bcast) begin
            if (d_ok) begin
              mode_d  = M_BCAST;
              d_d     = bus.req_d_idx;
              w_d     = '0;
              val_d   = bus.req_value;
              state_d = S_SETUP;
            end else begin
              err_d = 1'b1;
            end
          end else if (d_ok && w_ok) begin
            mode_d  = M_SINGLE;
            d_d     = bus.req_d_idx;
            w_d     = bus.req_w_idx;
            val_d   = bus.req_value;
            state_d = S_SETUP;
          end else begin
            // Rejected commands are consumed without touching the memory.
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: state_d = S_EXEC;
      S_EXEC:  state_d = S_HOLD;
      S_HOLD: begin
        if (cmd_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SETUP;
          // Lane is the inner loop. Both counters stop at their last valid
          // index, so a non-power-of-2 size never reaches a missing entry.
          if (!w_last) begin
            w_d = w_q + WW'(1);
          end else if (mode_q == M_CLEAR && !d_last) begin
            w_d = '0;
            d_d = d_q + DW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_EXEC && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_adc or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      mode_q  <= M_SINGLE;
      d_q     <= '0;
      w_q     <= '0;
      val_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      d_q     <= d_d;
      w_q     <= w_d;
      val_q   <= val_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The outputs are decoded straight from registered state. The
  // asynchronous reset therefore removes the strobe at once.
  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.wme_ffe_exec = (state_q == S_EXEC);
  assign bus.done         = (state_q == S_HOLD) && cmd_last;
  assign bus.err          = err_q;
  assign bus.wme_ffe_inst = {1'b0, w_q, d_q};  // rd_wrb = 0: write only
  assign bus.wme_ffe_data = val_q;
  assign bus.wr_count     = cnt_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_ffe_weight_sequencer.sv
module tb_ffe_weight_sequencer;
  localparam int FL = 10;
  localparam int CW = 16;
  localparam int WP = 10;
  localparam int CN = 16;
  localparam int DW = 4;
  localparam int WW = 4;
  localparam int EW = 1 + WW + DW + WP;

  // ---------------- clock / reset ----------------
  logic clk_adc = 1'b0;
  logic rstb;
  always #5 clk_adc = ~clk_adc;

  ffe_weight_sequencer_if #(.FFE_LENGTH(FL), .CHANNEL_WIDTH(CW), .WEIGHT_PREC(WP), .CNT_W(CN)) bus ();

  ffe_weight_sequencer #(.FFE_LENGTH(FL), .CHANNEL_WIDTH(CW), .WEIGHT_PREC(WP), .CNT_W(CN)) dut (
    .clk_adc (clk_adc),
    .rstb    (rstb),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  always @(posedge clk_adc) cyc <= cyc + 1;

  // ---------------- write monitor + memory model ----------------
  logic [EW-1:0] obs_q[$];
  logic [EW-1:0] exp_q[$];
  logic [WP-1:0] mem [FL][CW];

  always @(negedge clk_adc) begin
    if (rstb && bus.wme_ffe_exec) begin
      obs_q.push_back({bus.wme_ffe_inst, bus.wme_ffe_data});
      if (int'(bus.wme_ffe_inst[DW-1:0]) < FL)
        mem[bus.wme_ffe_inst[DW-1:0]][bus.wme_ffe_inst[DW+WW-1:DW]] = bus.wme_ffe_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic clr, input logic bc, input logic [DW-1:0] d,
                      input logic [WW-1:0] w, input logic [WP-1:0] v);
    @(negedge clk_adc);
    bus.req_clear = clr;
    bus.req_bcast = bc;
    bus.req_d_idx = d;
    bus.req_w_idx = w;
    bus.req_value = v;
    bus.req_valid = 1'b1;
    @(posedge clk_adc);
    #1;
    bus.req_valid = 1'b0;
  endtask

  int busy_cyc, done_cnt, gap_bad;
  logic timed_out;

  // Samples 1ns after every edge while busy; records busy length, done
  // pulses and exec spacing errors.
  task automatic run_until_idle();
    int k, last;
    busy_cyc = 0; done_cnt = 0; gap_bad = 0; last = -1; k = 0;
    while (bus.busy && k < 2000) begin
      busy_cyc++;
      if (bus.done) done_cnt++;
      if (bus.wme_ffe_exec) begin
        if (last >= 0 && k - last != 3) gap_bad++;
        last = k;
      end
      k++;
      @(posedge clk_adc);
      #1;
    end
    timed_out = bus.busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstb = 1'b0;
    bus.req_valid = 1'b0; bus.req_clear = 1'b0; bus.req_bcast = 1'b0;
    bus.req_d_idx = '0; bus.req_w_idx = '0; bus.req_value = '0;
    repeat (3) @(posedge clk_adc);
    #1;
    tests_run++;
    if ({bus.req_ready, bus.busy, bus.wme_ffe_exec, bus.done, bus.err} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 10000",
               {bus.req_ready, bus.busy, bus.wme_ffe_exec, bus.done, bus.err});
    end
    tests_run++;
    if ({bus.wme_ffe_inst, bus.wme_ffe_data, bus.wr_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: inst=%h data=%h cnt=%0d required all 0",
               bus.wme_ffe_inst, bus.wme_ffe_data, bus.wr_count);
    end
    @(negedge clk_adc);
    rstb = 1'b1;
  endtask

  task automatic test_single();
    obs_q.delete();
    send(1'b0, 1'b0, 4'd1, 4'd3, 10'h3A9);  // -87
    tests_run++;
    if ({bus.req_ready, bus.busy, bus.wme_ffe_exec, bus.done} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL single_setup: rdy/busy/exec/done=%b required 0100",
               {bus.req_ready, bus.busy, bus.wme_ffe_exec, bus.done});
    end
    @(posedge clk_adc); #1;
    tests_run++;
    if ({bus.wme_ffe_exec, bus.wme_ffe_inst, bus.wme_ffe_data} !== {1'b1, 9'h031, 10'h3A9}) begin
      tests_failed++;
      $display("FAIL single_exec: exec=%b inst=%h data=%h required 1 031 3a9",
               bus.wme_ffe_exec, bus.wme_ffe_inst, bus.wme_ffe_data);
    end
    @(posedge clk_adc); #1;
    tests_run++;
    if ({bus.done, bus.wme_ffe_exec, bus.req_ready} !== 3'b100) begin
      tests_failed++;
      $display("FAIL single_done: done/exec/rdy=%b required 100",
               {bus.done, bus.wme_ffe_exec, bus.req_ready});
    end
    @(posedge clk_adc); #1;
    tests_run++;
    if ({bus.req_ready, bus.busy, bus.done} !== 3'b100 || bus.wr_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL single_end: rdy/busy/done=%b cnt=%0d required 100 cnt=1",
               {bus.req_ready, bus.busy, bus.done}, bus.wr_count);
    end
    tests_run++;
    if (obs_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL single_pulses: got %0d exec pulses required 1", obs_q.size());
    end
  endtask

  task automatic test_bcast();
    int bad;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < CW; i++) exp_q.push_back({1'b0, WW'(i), 4'd0, 10'h3FF});
    send(1'b0, 1'b1, 4'd0, 4'd7, 10'h3FF);  // 2047 truncated to 10 bits
    run_until_idle();
    tests_run++;
    if (timed_out !== 1'b0 || busy_cyc != 48 || done_cnt != 1 || gap_bad != 0) begin
      tests_failed++;
      $display("FAIL bcast_timing: timeout=%b busy=%0d done=%0d badgaps=%0d required 0 48 1 0",
               timed_out, busy_cyc, done_cnt, gap_bad);
    end
    bad = 0;
    tests_run++;
    if (obs_q.size() != exp_q.size()) bad = 1;
    else for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL bcast_writes: got %0d writes (%0d wrong) required 16 in lane order",
               obs_q.size(), bad);
    end
    tests_run++;
    if (bus.wr_count !== 16'd17) begin
      tests_failed++;
      $display("FAIL bcast_count: got %0d required 17", bus.wr_count);
    end
  endtask

  task automatic test_clear();
    int bad, nz;
    for (int d = 0; d < FL; d++) for (int w = 0; w < CW; w++) mem[d][w] = 10'h155;
    obs_q.delete(); exp_q.delete();
    for (int d = 0; d < FL; d++)
      for (int w = 0; w < CW; w++) exp_q.push_back({1'b0, WW'(w), DW'(d), 10'h000});
    send(1'b1, 1'b0, 4'd3, 4'd5, 10'h2AA);
    run_until_idle();
    tests_run++;
    if (timed_out !== 1'b0 || busy_cyc != 480 || done_cnt != 1 || gap_bad != 0) begin
      tests_failed++;
      $display("FAIL clear_timing: timeout=%b busy=%0d done=%0d badgaps=%0d required 0 480 1 0",
               timed_out, busy_cyc, done_cnt, gap_bad);
    end
    bad = 0;
    tests_run++;
    if (obs_q.size() != exp_q.size()) bad = 1;
    else for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL clear_writes: got %0d writes (%0d wrong) required 160 d-outer/w-inner zeros",
               obs_q.size(), bad);
    end
    nz = 0;
    for (int d = 0; d < FL; d++) for (int w = 0; w < CW; w++) if (mem[d][w] !== '0) nz++;
    tests_run++;
    if (nz != 0) begin
      tests_failed++;
      $display("FAIL clear_memory: got %0d nonzero entries required 0", nz);
    end
    tests_run++;
    if (bus.wr_count !== 16'd177) begin
      tests_failed++;
      $display("FAIL clear_count: got %0d required 177", bus.wr_count);
    end
  endtask

  task automatic test_invalid();
    obs_q.delete();
    send(1'b0, 1'b0, 4'd12, 4'd0, 10'h001);
    tests_run++;
    if ({bus.req_ready, bus.busy, bus.err, bus.done} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL invalid_err: rdy/busy/err/done=%b required 1010",
               {bus.req_ready, bus.busy, bus.err, bus.done});
    end
    @(posedge clk_adc); #1;
    tests_run++;
    if ({bus.req_ready, bus.err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL invalid_pulse: rdy/err=%b required 10", {bus.req_ready, bus.err});
    end
    send(1'b0, 1'b1, 4'd10, 4'd0, 10'h001);  // bcast, d one past the end
    tests_run++;
    if ({bus.req_ready, bus.err} !== 2'b11) begin
      tests_failed++;
      $display("FAIL invalid_bcast: rdy/err=%b required 11", {bus.req_ready, bus.err});
    end
    repeat (4) @(posedge clk_adc);
    #1;
    tests_run++;
    if (obs_q.size() != 0 || bus.wr_count !== 16'd177) begin
      tests_failed++;
      $display("FAIL invalid_noexec: writes=%0d cnt=%0d required 0 177", obs_q.size(), bus.wr_count);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    send(1'b0, 1'b1, 4'd2, 4'd0, 10'h005);
    k = 0;
    while (!bus.wme_ffe_exec && k < 10) begin
      @(posedge clk_adc); #1; k++;
    end
    tests_run++;
    if (bus.wme_ffe_exec !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_start: exec=%b required 1 within 10 cycles", bus.wme_ffe_exec);
    end
    #2;
    rstb = 1'b0;
    #1;
    obs_q.delete();
    tests_run++;
    if ({bus.req_ready, bus.busy, bus.wme_ffe_exec, bus.done, bus.err} !== 5'b10000 ||
        {bus.wme_ffe_inst, bus.wme_ffe_data, bus.wr_count} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_async: flags=%b inst=%h data=%h cnt=%0d required 10000 0 0 0",
               {bus.req_ready, bus.busy, bus.wme_ffe_exec, bus.done, bus.err},
               bus.wme_ffe_inst, bus.wme_ffe_data, bus.wr_count);
    end
    repeat (2) @(posedge clk_adc);
    @(negedge clk_adc);
    rstb = 1'b1;
    repeat (6) @(posedge clk_adc);
    #1;
    tests_run++;
    if (obs_q.size() != 0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_noresume: writes=%0d busy=%b required 0 0", obs_q.size(), bus.busy);
    end
    send(1'b0, 1'b0, 4'd9, 4'd15, 10'h001);  // last valid tap and lane
    run_until_idle();
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b0, 4'd15, 4'd9, 10'h001} || bus.wr_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL rstmid_after: writes=%0d first=%h cnt=%0d required 1 %h 1",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : '0, bus.wr_count,
               {1'b0, 4'd15, 4'd9, 10'h001});
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] dv [3];
    logic [WW-1:0] wv [3];
    logic [WP-1:0] vv [3];
    int acc [3];
    int k, bad;
    dv = '{4'd2, 4'd7, 4'd9};
    wv = '{4'd4, 4'd0, 4'd15};
    vv = '{10'h011, 10'h200, 10'h3FF};
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, wv[i], dv[i], vv[i]});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_adc);
      bus.req_clear = 1'b0; bus.req_bcast = 1'b0;
      bus.req_d_idx = dv[i]; bus.req_w_idx = wv[i]; bus.req_value = vv[i];
      bus.req_valid = 1'b1;
      k = 0;
      while (!bus.req_ready && k < 20) begin
        @(negedge clk_adc); k++;
      end
      acc[i] = cyc;
      @(posedge clk_adc);
    end
    @(negedge clk_adc);
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk_adc);
    #1;
    tests_run++;
    if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d,%0d cycles between accepts required 4,4",
               acc[1] - acc[0], acc[2] - acc[1]);
    end
    bad = 0;
    tests_run++;
    if (obs_q.size() != 3) bad = 1;
    else for (int i = 0; i < 3; i++) if (obs_q[i] !== exp_q[i]) bad++;
    if (bad != 0 || bus.wr_count !== 16'd4) begin
      tests_failed++;
      $display("FAIL b2b_writes: got %0d writes (%0d wrong) cnt=%0d required 3 writes cnt=4",
               obs_q.size(), bad, bus.wr_count);
    end
    obs_q.delete();
    send(1'b1, 1'b1, 4'd4, 4'd0, 10'h123);  // clear wins over bcast
    run_until_idle();
    tests_run++;
    if (obs_q.size() != 160 || busy_cyc != 480 || done_cnt != 1 ||
        obs_q[0] !== {1'b0, 4'd0, 4'd0, 10'h000} ||
        obs_q[obs_q.size()-1] !== {1'b0, 4'd15, 4'd9, 10'h000} || bus.wr_count !== 16'd164) begin
      tests_failed++;
      $display("FAIL clr_priority: writes=%0d busy=%0d done=%0d cnt=%0d required 160 480 1 164",
               obs_q.size(), busy_cyc, done_cnt, bus.wr_count);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_bcast();
    test_clear();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
